bank_timing_tracker: RTL and testbench
======================================

BANK_TIMING_TRACKER -- requirements
Module: bank_timing_tracker

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 8, meaning the number of tracked banks (power of 2, 2..16).
REQ-002 SHALL have parameter CNT_W, default 7, meaning the per-bank counter width.
REQ-003 SHALL have timing parameters, in cycles: T_RCD=5, T_RP=5, T_RAS=15, T_RTP=4, T_WR=6, T_WL=5, T_RRD=4, T_FAW=20, T_RFC=44.
REQ-004 SHALL have ports: clk input 1, the single clock; rst input 1, a synchronous active-high reset.
REQ-005 SHALL have ports: cmd_valid input 1; cmd input 3 (NOP/ACT/RD/WR/PRE/PREA/REF); cmd_bank input log2(NUM_BANKS); auto_pre input 1; bl4 input 1 (1 = fixed BL4, 0 = BL8/on-the-fly).
REQ-006 SHALL have ports: act_ok, rdwr_ok, pre_ok outputs, each NUM_BANKS wide, giving per-bank command-legal flags.
REQ-007 SHALL have ports: ref_ok output 1; bank_open output NUM_BANKS; last_cmd output 3*NUM_BANKS (per-bank record code 1..6, same encoding as the existing tracker); protocol_err output 1, sticky.

Function
REQ-008 SHALL sample a command only when cmd_valid=1; a command is issued at edge N.
REQ-009 SHALL give each bank three down-counters (act_cnt, rdwr_cnt, pre_cnt), each saturating at 0.
REQ-010 SHALL compute each ok flag combinationally as (its counter == 0) gated by the state in REQ-016..018, so that for load value T-1 the next command is legal at edge N+T; T=1 never deasserts ok.
REQ-011 SHALL load a counter with max(current, new), never overwriting a longer pending constraint.
REQ-012 SHALL apply on ACT to bank b: rdwr_cnt=T_RCD-1; pre_cnt=T_RAS-1; act_cnt=T_RAS+T_RP-1 (tRC); bank_open[b]=1; last_cmd=3.
REQ-013 SHALL apply on RD: pre_cnt=T_RTP-1 and last_cmd=4; with auto_pre, additionally act_cnt=T_RTP+T_RP-1, bank_open=0 and last_cmd=6.
REQ-014 SHALL apply on WR with D=T_WL+(bl4?2:4)+T_WR: pre_cnt=D-1 and last_cmd=1; with auto_pre, additionally act_cnt=D+T_RP-1, bank_open=0 and last_cmd=5.
REQ-015 SHALL apply on PRE: act_cnt=T_RP-1, bank_open=0 and last_cmd=2; PREA SHALL do the same for all open banks.
REQ-016 SHALL apply on REF: act_cnt of all banks=T_RFC-1; ref_ok=0 for T_RFC cycles.
REQ-017 SHALL apply rank-level gating of act_ok: a tRRD counter loaded T_RRD-1 on every ACT; a tFAW window of 4 slot counters, with ACT loading T_FAW-1 into the lowest-index zero slot; all bits of act_ok=0 while the tRRD counter≠0 or all 4 slots≠0.
REQ-018 SHALL gate by bank state: act_ok[b] requires bank_open[b]=0; rdwr_ok[b] requires bank_open[b]=1; ref_ok requires all banks closed, all act_cnt=0 and the tRFC counter=0.
REQ-019 SHALL set protocol_err on a command whose corresponding ok bit is 0 at issue; the command SHALL still be applied and the flag held until rst.
REQ-020 SHALL decrement the counters of banks other than cmd_bank on the same edge as a command to cmd_bank.
REQ-021 SHALL add no pipeline latency: a command at edge N is reflected in the outputs after edge N.

Reset
REQ-022 SHALL, when rst=1 at an edge, clear all counters, tFAW slots, bank_open, last_cmd and protocol_err.
REQ-023 SHALL, after reset, drive act_ok=all 1, rdwr_ok=0, pre_ok=all 1 and ref_ok=1.
REQ-024 SHALL give rst priority over a simultaneous command, which is dropped.

Structure
REQ-025 SHALL take the command encodings, record codes and default timing constants from the shared controller package.
REQ-026 SHALL implement per-bank counters, bank_open and last_cmd in sub-module bank_timer, instantiated NUM_BANKS times via generate.
REQ-027 SHALL keep tRRD, tFAW and tRFC logic at top level.

Verification
REQ-028 SHALL cover: ACT b0 @0 -> rdwr_ok[0]=0 for edges 1-4, 1 @5; pre_ok[0]=1 @15; act_ok[0] stays 0 until PRE+5.
REQ-029 SHALL cover: ACT b0 @0, WR BL8 b0 @5 -> pre_ok[0]=0 until @20 (5+15); with auto_pre -> act_ok[0]=1 @25, last_cmd[0]=5.
REQ-030 SHALL cover: ACT b0..b3 @0,4,8,12; ACT b4 @16 -> tFAW blocks act_ok until @20.
REQ-031 SHALL cover: RD b0 @10 after a WR load of @20 -> pre_cnt keeps 20 (max rule), pre_ok[0]=1 @20.
REQ-032 SHALL cover: REF with all banks closed @0 -> ref_ok and act_ok=0 until @44; RD to a closed bank -> protocol_err=1, held.
REQ-033 SHALL cover: rst asserted mid-tRAS together with an ACT -> the ACT is ignored and the next cycle shows reset values per REQ-023.

Source files
------------

// File: rtl/bank_timing_tracker_pkg.sv
// Shared controller definitions: command encodings, per-bank record codes and
// default DRAM timing constants (in clock cycles).
package bank_timing_tracker_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_e;

  typedef enum logic [2:0] {
    REC_NONE = 3'd0,
    REC_WR   = 3'd1,
    REC_PRE  = 3'd2,
    REC_ACT  = 3'd3,
    REC_RD   = 3'd4,
    REC_WRA  = 3'd5,
    REC_RDA  = 3'd6
  } rec_e;

  localparam int DEF_T_RCD = 5;
  localparam int DEF_T_RP  = 5;
  localparam int DEF_T_RAS = 15;
  localparam int DEF_T_RTP = 4;
  localparam int DEF_T_WR  = 6;
  localparam int DEF_T_WL  = 5;
  localparam int DEF_T_RRD = 4;
  localparam int DEF_T_FAW = 20;
  localparam int DEF_T_RFC = 44;

  // Data-bus cycles of a write burst: BL4 takes 2 clocks, BL8/OTF takes 4.
  localparam int BL4_CYC   = 2;
  localparam int BL8_CYC   = 4;
  localparam int FAW_SLOTS = 4;

endpackage

// File: rtl/bank_timing_tracker_bank_timer.sv
// One bank's timing state: ACT/RDWR/PRE down-counters, open flag and the
// record code of the last command that touched the bank.
module bank_timer
  import bank_timing_tracker_pkg::*;
#(
  parameter int CNT_W = 7,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_RTP = DEF_T_RTP,
  parameter int T_WR  = DEF_T_WR,
  parameter int T_WL  = DEF_T_WL,
  parameter int T_RFC = DEF_T_RFC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic [2:0] cmd,
  input  logic       auto_pre,
  input  logic       bl4,
  input  logic       ref_all,
  input  logic       prea_all,
  output logic       act_idle,
  output logic       rdwr_idle,
  output logic       pre_idle,
  output logic       open,
  output logic [2:0] last
);

  localparam logic [CNT_W-1:0] LD_RCD  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RAS  = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] LD_RC   = CNT_W'(T_RAS + T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RTP  = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] LD_RDA  = CNT_W'(T_RTP + T_RP - 1);
  localparam logic [CNT_W-1:0] LD_WR4  = CNT_W'(T_WL + BL4_CYC + T_WR - 1);
  localparam logic [CNT_W-1:0] LD_WR8  = CNT_W'(T_WL + BL8_CYC + T_WR - 1);
  localparam logic [CNT_W-1:0] LD_WRA4 = CNT_W'(T_WL + BL4_CYC + T_WR + T_RP - 1);
  localparam logic [CNT_W-1:0] LD_WRA8 = CNT_W'(T_WL + BL8_CYC + T_WR + T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(T_RFC - 1);

  logic [CNT_W-1:0] act_cnt, rdwr_cnt, pre_cnt;
  logic [CNT_W-1:0] act_n, rdwr_n, pre_n;
  logic             open_n;
  logic [2:0]       last_n;

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  // Loads are taken against the already-decremented value so an earlier,
  // longer deadline is kept exactly.
  function automatic logic [CNT_W-1:0] upd(input logic [CNT_W-1:0] d,
                                           input logic [CNT_W-1:0] ld);
    return (ld > d) ? ld : d;
  endfunction

  always_comb begin
    act_n  = dec(act_cnt);
    rdwr_n = dec(rdwr_cnt);
    pre_n  = dec(pre_cnt);
    open_n = open;
    last_n = last;
    if (ref_all) act_n = upd(act_n, LD_RFC);
    if (prea_all && open) begin
      act_n  = upd(act_n, LD_RP);
      open_n = 1'b0;
      last_n = REC_PRE;
    end
    if (hit) begin
      case (cmd)
        CMD_ACT: begin
          rdwr_n = upd(rdwr_n, LD_RCD);
          pre_n  = upd(pre_n, LD_RAS);
          act_n  = upd(act_n, LD_RC);
          open_n = 1'b1;
          last_n = REC_ACT;
        end
        CMD_RD: begin
          pre_n  = upd(pre_n, LD_RTP);
          last_n = REC_RD;
          if (auto_pre) begin
            act_n  = upd(act_n, LD_RDA);
            open_n = 1'b0;
            last_n = REC_RDA;
          end
        end
        CMD_WR: begin
          pre_n  = upd(pre_n, bl4 ? LD_WR4 : LD_WR8);
          last_n = REC_WR;
          if (auto_pre) begin
            act_n  = upd(act_n, bl4 ? LD_WRA4 : LD_WRA8);
            open_n = 1'b0;
            last_n = REC_WRA;
          end
        end
        CMD_PRE: begin
          act_n  = upd(act_n, LD_RP);
          open_n = 1'b0;
          last_n = REC_PRE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt  <= '0;
      rdwr_cnt <= '0;
      pre_cnt  <= '0;
      open     <= 1'b0;
      last     <= '0;
    end else begin
      act_cnt  <= act_n;
      rdwr_cnt <= rdwr_n;
      pre_cnt  <= pre_n;
      open     <= open_n;
      last     <= last_n;
    end
  end

  assign act_idle  = (act_cnt == '0);
  assign rdwr_idle = (rdwr_cnt == '0);
  assign pre_idle  = (pre_cnt == '0);

endmodule

// File: rtl/bank_timing_tracker.sv
// Rank timing tracker: per-bank timers plus rank-wide tRRD, tFAW and tRFC,
// producing per-bank command-legal flags and a sticky protocol error.
module bank_timing_tracker
  import bank_timing_tracker_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int CNT_W     = 7,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RP      = DEF_T_RP,
  parameter int T_RAS     = DEF_T_RAS,
  parameter int T_RTP     = DEF_T_RTP,
  parameter int T_WR      = DEF_T_WR,
  parameter int T_WL      = DEF_T_WL,
  parameter int T_RRD     = DEF_T_RRD,
  parameter int T_FAW     = DEF_T_FAW,
  parameter int T_RFC     = DEF_T_RFC,
  localparam int BW       = $clog2(NUM_BANKS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [2:0]             cmd,
  input  logic [BW-1:0]          cmd_bank,
  input  logic                   auto_pre,
  input  logic                   bl4,
  output logic [NUM_BANKS-1:0]   act_ok,
  output logic [NUM_BANKS-1:0]   rdwr_ok,
  output logic [NUM_BANKS-1:0]   pre_ok,
  output logic                   ref_ok,
  output logic [NUM_BANKS-1:0]   bank_open,
  output logic [3*NUM_BANKS-1:0] last_cmd,
  output logic                   protocol_err
);

  localparam logic [CNT_W-1:0] LD_RRD = CNT_W'(T_RRD - 1);
  localparam logic [CNT_W-1:0] LD_FAW = CNT_W'(T_FAW - 1);
  localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);

  logic                             is_act, is_ref, is_prea;
  logic [NUM_BANKS-1:0]             hit, act_idle, rdwr_idle, pre_idle;
  logic [CNT_W-1:0]                 rrd_cnt, rrd_n, rfc_cnt, rfc_n;
  logic [FAW_SLOTS-1:0][CNT_W-1:0]  faw, faw_n;
  logic [FAW_SLOTS-1:0]             faw_busy;
  logic                             found, rank_ok, bad;

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  assign is_act  = cmd_valid && (cmd == CMD_ACT);
  assign is_ref  = cmd_valid && (cmd == CMD_REF);
  assign is_prea = cmd_valid && (cmd == CMD_PREA);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign hit[b] = cmd_valid && (cmd_bank == BW'(b));

    bank_timer #(
      .CNT_W(CNT_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
      .T_RTP(T_RTP), .T_WR(T_WR), .T_WL(T_WL), .T_RFC(T_RFC)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .hit      (hit[b]),
      .cmd      (cmd),
      .auto_pre (auto_pre),
      .bl4      (bl4),
      .ref_all  (is_ref),
      .prea_all (is_prea),
      .act_idle (act_idle[b]),
      .rdwr_idle(rdwr_idle[b]),
      .pre_idle (pre_idle[b]),
      .open     (bank_open[b]),
      .last     (last_cmd[3*b +: 3])
    );

    assign act_ok[b]  = act_idle[b] & ~bank_open[b] & rank_ok;
    assign rdwr_ok[b] = rdwr_idle[b] & bank_open[b];
    assign pre_ok[b]  = pre_idle[b];
  end

  always_comb begin
    for (int i = 0; i < FAW_SLOTS; i++) faw_busy[i] = (faw[i] != '0);
  end

  assign rank_ok = (rrd_cnt == '0) && !(&faw_busy);
  assign ref_ok  = !(|bank_open) && (&act_idle) && (rfc_cnt == '0);

  // An ACT takes the lowest free tFAW slot; an illegal ACT with all slots
  // busy takes none, so the window keeps tracking the four legal ones.
  always_comb begin
    rrd_n = dec(rrd_cnt);
    rfc_n = dec(rfc_cnt);
    found = 1'b0;
    for (int i = 0; i < FAW_SLOTS; i++) faw_n[i] = dec(faw[i]);
    if (is_act) begin
      rrd_n = (LD_RRD > rrd_n) ? LD_RRD : rrd_n;
      for (int i = 0; i < FAW_SLOTS; i++) begin
        if (!found && !faw_busy[i]) begin
          faw_n[i] = LD_FAW;
          found    = 1'b1;
        end
      end
    end
    if (is_ref) rfc_n = (LD_RFC > rfc_n) ? LD_RFC : rfc_n;
  end

  always_comb begin
    bad = 1'b0;
    if (cmd_valid) begin
      case (cmd)
        CMD_ACT:        bad = ~act_ok[cmd_bank];
        CMD_RD, CMD_WR: bad = ~rdwr_ok[cmd_bank];
        CMD_PRE:        bad = ~pre_ok[cmd_bank];
        CMD_PREA:       bad = |(bank_open & ~pre_ok);
        CMD_REF:        bad = ~ref_ok;
        default:        bad = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_cnt      <= '0;
      rfc_cnt      <= '0;
      faw          <= '0;
      protocol_err <= 1'b0;
    end else begin
      rrd_cnt      <= rrd_n;
      rfc_cnt      <= rfc_n;
      faw          <= faw_n;
      protocol_err <= protocol_err | bad;
    end
  end

endmodule

// File: tb/tb_bank_timing_tracker.sv
// Directed vector table for the timing corner cases plus randomized traffic
// checked against an absolute-deadline reference model.
module tb_bank_timing_tracker;

  localparam int NB = 8;
  localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                         PRE = 3'd4, PREA = 3'd5, REF = 3'd6;
  localparam int TRCD = 5, TRP = 5, TRAS = 15, TRTP = 4, TWR = 6, TWL = 5,
                 TRRD = 4, TFAW = 20, TRFC = 44;

  logic            clk = 1'b0;
  logic            rst, cmd_valid, auto_pre, bl4;
  logic [2:0]      cmd, cmd_bank;
  logic [NB-1:0]   act_ok, rdwr_ok, pre_ok, bank_open;
  logic [3*NB-1:0] last_cmd;
  logic            ref_ok, protocol_err;

  bank_timing_tracker dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
    .auto_pre(auto_pre), .bl4(bl4), .act_ok(act_ok), .rdwr_ok(rdwr_ok),
    .pre_ok(pre_ok), .ref_ok(ref_ok), .bank_open(bank_open), .last_cmd(last_cmd),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Model: each constraint is the absolute edge index from which it is met.
  int act_rdy[NB], rdwr_rdy[NB], pre_rdy[NB], mlast[NB];
  bit mopen[NB];
  int rrd_rdy, rfc_rdy;
  int faw_exp[4];
  bit merr;

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void m_reset();
    for (int b = 0; b < NB; b++) begin
      act_rdy[b] = 0; rdwr_rdy[b] = 0; pre_rdy[b] = 0; mlast[b] = 0; mopen[b] = 0;
    end
    for (int i = 0; i < 4; i++) faw_exp[i] = 0;
    rrd_rdy = 0; rfc_rdy = 0; merr = 0;
  endfunction

  function automatic bit m_rank_ok(input int m);
    int free_slots = 0;
    for (int i = 0; i < 4; i++) if (faw_exp[i] <= m) free_slots++;
    return (rrd_rdy <= m) && (free_slots > 0);
  endfunction

  function automatic bit m_act_ok(input int b, input int m);
    return (act_rdy[b] <= m) && !mopen[b] && m_rank_ok(m);
  endfunction

  function automatic bit m_ref_ok(input int m);
    bit ok = (rfc_rdy <= m);
    for (int b = 0; b < NB; b++) if (mopen[b] || act_rdy[b] > m) ok = 0;
    return ok;
  endfunction

  function automatic bit m_legal(input logic [2:0] c, input int b, input int m);
    bit ok = 1;
    case (c)
      ACT:     ok = m_act_ok(b, m);
      RD, WR:  ok = (rdwr_rdy[b] <= m) && mopen[b];
      PRE:     ok = (pre_rdy[b] <= m);
      PREA:    for (int k = 0; k < NB; k++) if (mopen[k] && pre_rdy[k] > m) ok = 0;
      REF:     ok = m_ref_ok(m);
      default: ok = 1;
    endcase
    return ok;
  endfunction

  function automatic void m_apply(input logic [2:0] c, input int b, input bit ap,
                                  input bit b4, input int n);
    int d = TWL + (b4 ? 2 : 4) + TWR;
    bit placed = 0;
    if (!m_legal(c, b, n)) merr = 1;
    case (c)
      ACT: begin
        rdwr_rdy[b] = mx(rdwr_rdy[b], n + TRCD);
        pre_rdy[b]  = mx(pre_rdy[b], n + TRAS);
        act_rdy[b]  = mx(act_rdy[b], n + TRAS + TRP);
        mopen[b] = 1; mlast[b] = 3;
        rrd_rdy = mx(rrd_rdy, n + TRRD);
        for (int i = 0; i < 4; i++)
          if (!placed && faw_exp[i] <= n) begin faw_exp[i] = n + TFAW; placed = 1; end
      end
      RD: begin
        pre_rdy[b] = mx(pre_rdy[b], n + TRTP); mlast[b] = 4;
        if (ap) begin act_rdy[b] = mx(act_rdy[b], n + TRTP + TRP); mopen[b] = 0; mlast[b] = 6; end
      end
      WR: begin
        pre_rdy[b] = mx(pre_rdy[b], n + d); mlast[b] = 1;
        if (ap) begin act_rdy[b] = mx(act_rdy[b], n + d + TRP); mopen[b] = 0; mlast[b] = 5; end
      end
      PRE: begin act_rdy[b] = mx(act_rdy[b], n + TRP); mopen[b] = 0; mlast[b] = 2; end
      PREA:
        for (int k = 0; k < NB; k++)
          if (mopen[k]) begin act_rdy[k] = mx(act_rdy[k], n + TRP); mopen[k] = 0; mlast[k] = 2; end
      REF: begin
        for (int k = 0; k < NB; k++) act_rdy[k] = mx(act_rdy[k], n + TRFC);
        rfc_rdy = n + TRFC;
      end
      default: ;
    endcase
  endfunction

  task automatic check_model();
    logic [NB-1:0] ea, er, ep, eo;
    logic [3*NB-1:0] el;
    logic eref;
    for (int b = 0; b < NB; b++) begin
      ea[b] = m_act_ok(b, cyc);
      er[b] = (rdwr_rdy[b] <= cyc) && mopen[b];
      ep[b] = (pre_rdy[b] <= cyc);
      eo[b] = mopen[b];
      el[3*b +: 3] = 3'(mlast[b]);
    end
    eref = m_ref_ok(cyc);
    checks++;
    if (act_ok !== ea || rdwr_ok !== er || pre_ok !== ep || bank_open !== eo ||
        last_cmd !== el || ref_ok !== eref || protocol_err !== merr) begin
      errors++;
      $display("FAIL model cyc=%0d act %b/%b rdwr %b/%b pre %b/%b open %b/%b last %h/%h ref %b/%b err %b/%b (got/exp)",
               cyc, act_ok, ea, rdwr_ok, er, pre_ok, ep, bank_open, eo, last_cmd, el,
               ref_ok, eref, protocol_err, merr);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [2:0] c, input int b,
                       input bit ap, input bit b4);
    check_model();
    rst = r; cmd_valid = v; cmd = c; cmd_bank = 3'(b); auto_pre = ap; bl4 = b4;
    if (r) m_reset();
    else if (v) m_apply(c, b, ap, b4, cyc);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    bit newsc; int t; bit r; logic [2:0] c; int b; bit ap; bit b4;
    int chk; bit e_act, e_rdwr, e_pre, e_open; int e_last; bit e_ref, e_err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit ns, input int t, input bit r, input logic [2:0] c,
                     input int b, input bit ap, input bit b4, input int chk,
                     input bit ea, input bit er, input bit ep, input bit eo,
                     input int el, input bit eref, input bit eerr);
    vec_t e;
    e.newsc = ns; e.t = t; e.r = r; e.c = c; e.b = b; e.ap = ap; e.b4 = b4;
    e.chk = chk; e.e_act = ea; e.e_rdwr = er; e.e_pre = ep; e.e_open = eo;
    e.e_last = el; e.e_ref = eref; e.e_err = eerr;
    tbl.push_back(e);
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    logic [8:0] got, exp;
    got = {act_ok[v.chk], rdwr_ok[v.chk], pre_ok[v.chk], bank_open[v.chk],
           last_cmd[3*v.chk +: 3], ref_ok, protocol_err};
    exp = {v.e_act, v.e_rdwr, v.e_pre, v.e_open, 3'(v.e_last), v.e_ref, v.e_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d t=%0d bank%0d {act,rdwr,pre,open,last,ref,err} got %b required %b",
               idx, v.t, v.chk, got, exp);
    end
  endtask

  initial begin
    int base;
    logic [2:0] c;
    int b, pick;
    bit r, v;

    // tRAS/tRCD/tRC and PRE->ACT
    add(1,  0, 0, ACT, 0, 0, 0, 0,  1,0,1,0,0,1,0);
    add(0,  1, 0, NOP, 0, 0, 0, 0,  0,0,0,1,3,0,0);
    add(0,  4, 0, NOP, 0, 0, 0, 0,  0,0,0,1,3,0,0);
    add(0,  5, 0, RD,  0, 0, 0, 0,  0,1,0,1,3,0,0);
    add(0, 14, 0, NOP, 0, 0, 0, 0,  0,1,0,1,4,0,0);
    add(0, 15, 0, PRE, 0, 0, 0, 0,  0,1,1,1,4,0,0);
    add(0, 16, 0, NOP, 0, 0, 0, 0,  0,0,1,0,2,0,0);
    add(0, 19, 0, NOP, 0, 0, 0, 0,  0,0,1,0,2,0,0);
    add(0, 20, 0, NOP, 0, 0, 0, 0,  1,0,1,0,2,1,0);
    // WR BL8 recovery, then RD must not shorten it
    add(1,  0, 0, ACT, 0, 0, 0, 0,  1,0,1,0,0,1,0);
    add(0,  5, 0, WR,  0, 0, 0, 0,  0,1,0,1,3,0,0);
    add(0, 10, 0, RD,  0, 0, 0, 0,  0,1,0,1,1,0,0);
    add(0, 19, 0, NOP, 0, 0, 0, 0,  0,1,0,1,4,0,0);
    add(0, 20, 0, NOP, 0, 0, 0, 0,  0,1,1,1,4,0,0);
    // WR BL8 with auto-precharge
    add(1,  0, 0, ACT, 0, 0, 0, 0,  1,0,1,0,0,1,0);
    add(0,  5, 0, WR,  0, 1, 0, 0,  0,1,0,1,3,0,0);
    add(0,  6, 0, NOP, 0, 0, 0, 0,  0,0,0,0,5,0,0);
    add(0, 24, 0, NOP, 0, 0, 0, 0,  0,0,1,0,5,0,0);
    add(0, 25, 0, NOP, 0, 0, 0, 0,  1,0,1,0,5,1,0);
    // WR BL4 shortens write recovery by two
    add(1,  0, 0, ACT, 0, 0, 0, 0,  1,0,1,0,0,1,0);
    add(0,  5, 0, WR,  0, 0, 1, 0,  0,1,0,1,3,0,0);
    add(0, 17, 0, NOP, 0, 0, 0, 0,  0,1,0,1,1,0,0);
    add(0, 18, 0, NOP, 0, 0, 0, 0,  0,1,1,1,1,0,0);
    // REF blackout, then an illegal RD to a closed bank
    add(1,  0, 0, REF, 0, 0, 0, 0,  1,0,1,0,0,1,0);
    add(0,  1, 0, NOP, 0, 0, 0, 0,  0,0,1,0,0,0,0);
    add(0, 43, 0, NOP, 0, 0, 0, 0,  0,0,1,0,0,0,0);
    add(0, 44, 0, RD,  0, 0, 0, 0,  1,0,1,0,0,1,0);
    add(0, 45, 0, NOP, 0, 0, 0, 0,  1,0,0,0,4,1,1);
    add(0, 50, 0, NOP, 0, 0, 0, 0,  1,0,1,0,4,1,1);
    // tRRD and tFAW seen from bank 4
    add(1,  0, 0, ACT, 0, 0, 0, 4,  1,0,1,0,0,1,0);
    add(0,  4, 0, ACT, 1, 0, 0, 4,  1,0,1,0,0,0,0);
    add(0,  8, 0, ACT, 2, 0, 0, 4,  1,0,1,0,0,0,0);
    add(0, 12, 0, ACT, 3, 0, 0, 4,  1,0,1,0,0,0,0);
    add(0, 13, 0, NOP, 0, 0, 0, 4,  0,0,1,0,0,0,0);
    add(0, 16, 0, NOP, 0, 0, 0, 4,  0,0,1,0,0,0,0);
    add(0, 19, 0, NOP, 0, 0, 0, 4,  0,0,1,0,0,0,0);
    add(0, 20, 0, ACT, 4, 0, 0, 4,  1,0,1,0,0,0,0);
    add(0, 21, 0, NOP, 0, 0, 0, 4,  0,0,0,1,3,0,0);
    // reset mid-tRAS wins over a simultaneous ACT
    add(1,  0, 0, ACT, 0, 0, 0, 0,  1,0,1,0,0,1,0);
    add(0,  5, 1, ACT, 1, 0, 0, 0,  0,1,0,1,3,0,0);
    add(0,  6, 0, NOP, 0, 0, 0, 1,  1,0,1,0,0,1,0);
    add(0,  7, 0, NOP, 0, 0, 0, 0,  1,0,1,0,0,1,0);

    rst = 1; cmd_valid = 0; cmd = NOP; cmd_bank = 0; auto_pre = 0; bl4 = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    m_reset();

    base = 0;
    foreach (tbl[i]) begin
      if (tbl[i].newsc) begin
        cycle(1, 0, NOP, 0, 0, 0);
        base = cyc;
      end
      while (cyc - base < tbl[i].t) cycle(0, 0, NOP, 0, 0, 0);
      check_vec(tbl[i], i);
      cycle(tbl[i].r, tbl[i].c != NOP, tbl[i].c, tbl[i].b, tbl[i].ap, tbl[i].b4);
    end

    cycle(1, 0, NOP, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      pick = $urandom_range(0, 99);
      if      (pick < 30) c = ACT;
      else if (pick < 50) c = RD;
      else if (pick < 70) c = WR;
      else if (pick < 84) c = PRE;
      else if (pick < 88) c = PREA;
      else if (pick < 91) c = REF;
      else if (pick < 93) c = 3'd7;
      else                c = NOP;
      b = $urandom_range(0, NB - 1);
      r = ($urandom_range(0, 599) == 0);
      v = ($urandom_range(0, 9) != 0);
      if (v && !r && !m_legal(c, b, cyc) && $urandom_range(0, 99) < 92) c = NOP;
      cycle(r, v, c, b, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
